// File: rtl/dmem_responder_if.sv
// Data-memory request/response bus.
// Signal names keep the responder's point of view (_i = into responder, _o = out of it).
//   Request : dreqvalid_i, dreqready_o, dreqsize_i, dreqwrite_i, dreqhpl_i,
//             dreqaddr_i, dreqdata_i
//   Response: drspvalid_o, drspready_i, drsprerr_o, drspwerr_o, drspdata_o
// master = requester (core side), slave = dmem_responder.
interface dmem_responder_if;
   logic        dreqready_o;
   logic        dreqvalid_i;
   logic [1:0]  dreqsize_i;
   logic        dreqwrite_i;
   logic [1:0]  dreqhpl_i;
   logic [31:0] dreqaddr_i;
   logic [31:0] dreqdata_i;
   logic        drspready_i;
   logic        drspvalid_o;
   logic        drsprerr_o;
   logic        drspwerr_o;
   logic [31:0] drspdata_o;

   modport master (
      input  dreqready_o,
      output dreqvalid_i, dreqsize_i, dreqwrite_i, dreqhpl_i, dreqaddr_i, dreqdata_i,
      output drspready_i,
      input  drspvalid_o, drsprerr_o, drspwerr_o, drspdata_o
   );

   modport slave (
      output dreqready_o,
      input  dreqvalid_i, dreqsize_i, dreqwrite_i, dreqhpl_i, dreqaddr_i, dreqdata_i,
      input  drspready_i,
      output drspvalid_o, drsprerr_o, drspwerr_o, drspdata_o
   );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: a word-organised synchronous RAM behind a valid/ready request port,
// returning load data and access faults in order through a small response FIFO.
// Ports:
//   clk_i     - clock, all state on the rising edge
//   resetb_i  - asynchronous active-low reset (array contents are not reset)
//   clk_en_i  - clock enable; nothing advances on edges where it is low
//   bus       - dmem_responder_if.slave request/response bus
// Non-faulting stores are written at the accept edge and produce no response. Loads and
// faulting stores go accept -> capture register -> response FIFO -> drsp* outputs.
module dmem_responder #(
   parameter int unsigned C_MEM_DEPTH_X  = 10,
   parameter int unsigned C_FIFO_DEPTH_X = 2
) (
   input  logic             clk_i,
   input  logic             resetb_i,
   input  logic             clk_en_i,
   dmem_responder_if.slave  bus
);

   localparam int unsigned MemWords  = 2 ** C_MEM_DEPTH_X;
   localparam int unsigned FifoDepth = 2 ** C_FIFO_DEPTH_X;
   localparam int unsigned CntW      = C_FIFO_DEPTH_X + 1;

   typedef struct packed {
      logic        rerr;
      logic        werr;
      logic [31:0] data;
   } rsp_t;

   // ---------------------------------------------------------------- request decode
   logic                     ready;
   logic                     req_fire;
   logic                     fault;
   logic                     wr_en;
   logic                     rd_en;
   logic                     rsp_gen;
   logic [3:0]               byte_en;
   logic [4:0]               shamt;
   logic [31:0]              wdata;
   logic [C_MEM_DEPTH_X-1:0] widx;

   always_comb begin
      fault = 1'b0;
      unique case (bus.dreqsize_i)
         2'd0:    fault = 1'b0;
         2'd1:    fault = bus.dreqaddr_i[0];
         2'd2:    fault = |bus.dreqaddr_i[1:0];
         default: fault = 1'b1;
      endcase
      if (32'(bus.dreqaddr_i[31:2]) >= MemWords) begin
         fault = 1'b1;
      end
   end

   always_comb begin
      byte_en = 4'b0000;
      unique case (bus.dreqsize_i)
         2'd0:    byte_en = 4'b0001 << bus.dreqaddr_i[1:0];
         2'd1:    byte_en = bus.dreqaddr_i[1] ? 4'b1100 : 4'b0011;
         default: byte_en = 4'b1111;
      endcase
   end

   assign shamt    = {bus.dreqaddr_i[1:0], 3'b000};
   assign wdata    = bus.dreqdata_i << shamt;
   assign widx     = bus.dreqaddr_i[C_MEM_DEPTH_X+1:2];
   assign req_fire = bus.dreqvalid_i & ready & clk_en_i;
   assign wr_en    = req_fire & bus.dreqwrite_i & ~fault;
   assign rd_en    = req_fire & ~bus.dreqwrite_i & ~fault;
   // Loads and every faulting access get a response slot; clean stores do not.
   assign rsp_gen  = req_fire & (~bus.dreqwrite_i | fault);

   // Privilege level is accepted but plays no part in access checking.
   logic unused_hpl;
   assign unused_hpl = ^bus.dreqhpl_i;

   // ---------------------------------------------------------------- storage array
   logic [31:0] mem [MemWords];
   logic [31:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (byte_en[b]) begin
               mem[widx][8*b +: 8] <= wdata[8*b +: 8];
            end
         end
      end
      if (rd_en) begin
         rdata_q <= mem[widx];
      end
   end

   // ---------------------------------------------------------------- capture register
   logic       run_q;
   logic       cap_valid_q;
   logic       cap_rerr_q;
   logic       cap_werr_q;
   logic [1:0] cap_off_q;

   always_ff @(posedge clk_i or negedge resetb_i) begin
      if (!resetb_i) begin
         run_q       <= 1'b0;
         cap_valid_q <= 1'b0;
         cap_rerr_q  <= 1'b0;
         cap_werr_q  <= 1'b0;
         cap_off_q   <= 2'd0;
      end else if (clk_en_i) begin
         run_q       <= 1'b1;
         cap_valid_q <= rsp_gen;
         if (rsp_gen) begin
            cap_rerr_q <= fault & ~bus.dreqwrite_i;
            cap_werr_q <= fault & bus.dreqwrite_i;
            cap_off_q  <= bus.dreqaddr_i[1:0];
         end
      end
   end

   // ---------------------------------------------------------------- response FIFO
   rsp_t                      fifo_q [FifoDepth];
   rsp_t                      push_entry;
   logic [C_FIFO_DEPTH_X-1:0] wr_ptr_q;
   logic [C_FIFO_DEPTH_X-1:0] rd_ptr_q;
   logic [CntW-1:0]           cnt_q;
   logic [CntW:0]             outstanding;
   logic                      rsp_valid;
   logic                      push;
   logic                      pop;

   assign rsp_valid = (cnt_q != '0);
   // The ready gate guarantees a free slot for whatever sits in the capture register.
   assign push      = clk_en_i & cap_valid_q;
   assign pop       = clk_en_i & rsp_valid & bus.drspready_i;

   always_comb begin
      push_entry.rerr = cap_rerr_q;
      push_entry.werr = cap_werr_q;
      push_entry.data = (cap_rerr_q | cap_werr_q) ? 32'd0 : (rdata_q >> {cap_off_q, 3'b000});
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_q[wr_ptr_q] <= push_entry;
      end
   end

   always_ff @(posedge clk_i or negedge resetb_i) begin
      if (!resetb_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         unique case ({push, pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // Registered state only: no path from drspready_i or dreqvalid_i.
   assign outstanding = {1'b0, cnt_q} + (CntW+1)'(cap_valid_q);
   assign ready       = run_q & (outstanding < (CntW+1)'(FifoDepth));

   // ---------------------------------------------------------------- outputs
   assign bus.dreqready_o = ready;
   assign bus.drspvalid_o = rsp_valid;
   assign bus.drsprerr_o  = rsp_valid & fifo_q[rd_ptr_q].rerr;
   assign bus.drspwerr_o  = rsp_valid & fifo_q[rd_ptr_q].werr;
   assign bus.drspdata_o  = rsp_valid ? fifo_q[rd_ptr_q].data : 32'd0;

endmodule
